// File: rtl/wb_burst_sram_pkg.sv
// Shared constants for the Wishbone burst SRAM: cycle-type codes and FSM state encoding.
package wb_burst_sram_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ACK   = 2'b10,
        ST_BURST = 2'b11
    } state_t;

endpackage

// File: rtl/wb_burst_sram_if.sv
// Wishbone B4 classic/registered-feedback slave bus bundle for the burst SRAM.
interface wb_burst_sram_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wb_burst_sram_mem.sv
// Single-port byte-writable synchronous RAM, one-cycle read latency, read-before-write.
module wb_burst_sram_mem #(
    parameter int adr_width = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [adr_width-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           sel,
    input  logic                 we,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [0:(2**adr_width)-1];

    // byte-lane writes; the array itself is never cleared by reset
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we && sel[lane]) begin
                mem_r[addr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
    end

    // registered read port returns the pre-write contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0000_0000;
        end else begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/wb_burst_sram.sv
// Wishbone slave SRAM with programmable first-beat wait states and incrementing bursts.
module wb_burst_sram
    import wb_burst_sram_pkg::*;
#(
    parameter int adr_width   = 11,
    parameter int wait_states = 0
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    wb_burst_sram_if.slave  wb
);

    localparam logic [1:0] WAIT_LOAD = 2'(wait_states);

    state_t               state_r, state_s;
    logic [adr_width-1:0] cnt_r, cnt_s, ram_addr_s, adr_word_s;
    logic [1:0]           wait_r, wait_s;
    logic                 req_s, ack_s, ram_we_s;
    logic [31:0]          ram_q_s;

    assign req_s      = wb.wb_cyc_i & wb.wb_stb_i;
    assign adr_word_s = wb.wb_adr_i[adr_width+1:2];

    // state and counter registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wait_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            wait_r  <= wait_s;
        end
    end

    // next-state, word counter and wait counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        wait_s  = wait_r;
        if (!wb.wb_cyc_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wb.wb_stb_i) begin
                        cnt_s  = adr_word_s;
                        wait_s = WAIT_LOAD;
                        if (WAIT_LOAD == 2'd0) begin
                            state_s = ST_ACK;
                        end else begin
                            state_s = ST_WAIT;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wait_s = wait_r - 2'd1;
                    if (wait_r <= 2'd1) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_ACK, ST_BURST: begin
                    if (wb.wb_stb_i) begin
                        if (wb.wb_cti_i == CTI_INCR) begin
                            cnt_s   = cnt_r + adr_width'(1);
                            state_s = ST_BURST;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // ack decode and RAM port control; write beats keep the port on the counter
    always_comb begin
        ack_s      = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = cnt_r;
        case (state_r)
            ST_IDLE: ram_addr_s = adr_word_s;
            ST_WAIT: ram_addr_s = cnt_r;
            ST_ACK, ST_BURST: begin
                ack_s    = req_s;
                ram_we_s = req_s & wb.wb_we_i;
                if (req_s && !wb.wb_we_i && (wb.wb_cti_i == CTI_INCR)) begin
                    ram_addr_s = cnt_r + adr_width'(1);
                end else begin
                    ram_addr_s = cnt_r;
                end
            end
            default: ram_addr_s = cnt_r;
        endcase
    end

    assign wb.wb_ack_o = ack_s;
    assign wb.wb_dat_o = ack_s ? ram_q_s : 32'h0000_0000;

    wb_burst_sram_mem #(.adr_width(adr_width)) u_mem (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .addr  (ram_addr_s),
        .wdata (wb.wb_dat_i),
        .sel   (wb.wb_sel_i),
        .we    (ram_we_s),
        .rdata (ram_q_s)
    );

endmodule
